// File: rtl/enemy_pkg.sv
// enemy_pkg: shared constants for the enemy wave controller.
// Holds the one-hot sequencer state codes, the enemy type codes and the
// default position/damage widths used by enemy_wave_ctrl.
package enemy_pkg;

  // One-hot sequencer states: IDLE -> SPAWN -> DAMAGE -> MOVE -> COLLECT -> IDLE
  localparam int ST_W = 5;
  localparam logic [ST_W-1:0] ST_IDLE    = 5'b00001;
  localparam logic [ST_W-1:0] ST_SPAWN   = 5'b00010;
  localparam logic [ST_W-1:0] ST_DAMAGE  = 5'b00100;
  localparam logic [ST_W-1:0] ST_MOVE    = 5'b01000;
  localparam logic [ST_W-1:0] ST_COLLECT = 5'b10000;

  // Enemy type codes presented on spawn_type_out
  localparam logic [1:0] TYPE_NONE   = 2'b00;
  localparam logic [1:0] TYPE_BASIC  = 2'b01;
  localparam logic [1:0] TYPE_MEDIUM = 2'b10;
  localparam logic [1:0] TYPE_HEAVY  = 2'b11;

  // Default datapath widths
  localparam int POS_W_DEF = 9;
  localparam int DMG_W_DEF = 8;

endpackage

// File: rtl/enemy_wave_ctrl_front_select.sv
// enemy_front_select: purely combinational frontmost-enemy picker.
// Ports: pos_i (packed per-slot positions), alive_i (per-slot live flag);
// idx_o/pos_o/valid_o give the live slot with the largest position, lowest index on a tie.
module enemy_front_select #(
  parameter int N_SLOTS = 4,
  parameter int POS_W   = 9,
  parameter int IDX_W   = 2
) (
  input  logic [N_SLOTS*POS_W-1:0] pos_i,
  input  logic [N_SLOTS-1:0]       alive_i,
  output logic [IDX_W-1:0]         idx_o,
  output logic [POS_W-1:0]         pos_o,
  output logic                     valid_o
);

  // Scanning upward with a strict '>' keeps the earlier (lower) index on ties.
  always_comb begin
    idx_o   = '0;
    pos_o   = '0;
    valid_o = 1'b0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (alive_i[i] && (!valid_o || (pos_i[i*POS_W +: POS_W] > pos_o))) begin
        idx_o   = IDX_W'(i);
        pos_o   = pos_i[i*POS_W +: POS_W];
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/enemy_wave_ctrl.sv
// enemy_wave_ctrl: per-tick spawn/damage/move/collect sequencer for the enemy slot bank.
// Inputs: tick, spawn_req/spawn_type, player_front/player_damage, per-slot enemy_pos/dmg/dead.
// Outputs: can_spawn/spawn_type_out, move/damage strobes, unit_front, damage_in, front_pos/valid,
//          enemy_attack/attack_valid, spawn_drop and tick_overrun status pulses.
module enemy_wave_ctrl
  import enemy_pkg::*;
#(
  parameter int N_SLOTS = 4,
  parameter int POS_W   = POS_W_DEF,
  parameter int DMG_W   = DMG_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tick,
  input  logic                     spawn_req,
  input  logic [1:0]               spawn_type,
  input  logic [POS_W-1:0]         player_front,
  input  logic [DMG_W-1:0]         player_damage,
  input  logic [N_SLOTS*POS_W-1:0] enemy_pos,
  input  logic [N_SLOTS*DMG_W-1:0] enemy_dmg,
  input  logic [N_SLOTS-1:0]       enemy_dead,
  output logic [N_SLOTS-1:0]       can_spawn,
  output logic [1:0]               spawn_type_out,
  output logic                     move_scen,
  output logic                     damage_scen,
  output logic [POS_W-1:0]         unit_front,
  output logic [N_SLOTS*DMG_W-1:0] damage_in,
  output logic [POS_W-1:0]         front_pos,
  output logic                     front_valid,
  output logic [DMG_W-1:0]         enemy_attack,
  output logic                     attack_valid,
  output logic                     spawn_drop,
  output logic                     tick_overrun
);

  localparam int IDX_W = $clog2(N_SLOTS);
  localparam int SUM_W = DMG_W + 3;

  logic [ST_W-1:0]    state_q, state_d;
  logic               pend_v_q, pend_v_d;
  logic [1:0]         pend_type_q, pend_type_d;
  logic [N_SLOTS-1:0] reserved_q, reserved_d;
  logic [POS_W-1:0]   unit_front_q, unit_front_d;
  logic [DMG_W-1:0]   attack_q, attack_d;
  logic               attack_vld_q;
  logic [IDX_W-1:0]   front_idx_q;
  logic [POS_W-1:0]   front_pos_q;
  logic               front_valid_q;

  logic [IDX_W-1:0]   sel_idx;
  logic [POS_W-1:0]   sel_pos;
  logic               sel_valid;
  logic [N_SLOTS-1:0] free_slots;
  logic [N_SLOTS-1:0] spawn_onehot;
  logic               spawn_fire;
  logic [SUM_W-1:0]   attack_sum;

  enemy_front_select #(
    .N_SLOTS (N_SLOTS),
    .POS_W   (POS_W),
    .IDX_W   (IDX_W)
  ) u_front_select (
    .pos_i   (enemy_pos),
    .alive_i (~enemy_dead),
    .idx_o   (sel_idx),
    .pos_o   (sel_pos),
    .valid_o (sel_valid)
  );

  // A slot is free only once it reports dead and no deploy is still in flight.
  assign free_slots   = enemy_dead & ~reserved_q;
  assign spawn_onehot = free_slots & (~free_slots + N_SLOTS'(1));
  assign spawn_fire   = (state_q == ST_SPAWN) && pend_v_q && (|free_slots);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (tick) state_d = ST_SPAWN;
      ST_SPAWN:   state_d = ST_DAMAGE;
      ST_DAMAGE:  state_d = ST_MOVE;
      ST_MOVE:    state_d = ST_COLLECT;
      ST_COLLECT: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output decode; damage_in must be all-zero outside DAMAGE because the
  // enemies compare their health against it on every cycle.
  always_comb begin
    can_spawn      = '0;
    spawn_type_out = TYPE_NONE;
    move_scen      = 1'b0;
    damage_scen    = 1'b0;
    damage_in      = '0;
    tick_overrun   = tick && (state_q != ST_IDLE);
    spawn_drop     = spawn_req && pend_v_q && !spawn_fire;
    case (state_q)
      ST_SPAWN: begin
        if (spawn_fire) begin
          can_spawn      = spawn_onehot;
          spawn_type_out = pend_type_q;
        end
      end
      ST_DAMAGE: begin
        damage_scen = 1'b1;
        if (front_valid_q) damage_in[front_idx_q*DMG_W +: DMG_W] = player_damage;
      end
      ST_MOVE: move_scen = 1'b1;
      default: ;
    endcase
  end

  // Pending entry, reservations, unit_front capture and attack sum
  always_comb begin
    pend_v_d    = pend_v_q;
    pend_type_d = pend_type_q;
    if (spawn_fire) pend_v_d = 1'b0;
    // A request arriving as the entry is consumed refills it.
    if (spawn_req && (!pend_v_q || spawn_fire)) begin
      pend_v_d    = 1'b1;
      pend_type_d = spawn_type;
    end

    reserved_d = (reserved_q & enemy_dead) | (spawn_fire ? spawn_onehot : '0);

    unit_front_d = ((state_q == ST_IDLE) && tick) ? player_front : unit_front_q;

    attack_sum = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (!enemy_dead[i]) attack_sum = attack_sum + SUM_W'(enemy_dmg[i*DMG_W +: DMG_W]);
    end
    attack_d = attack_q;
    if (state_q == ST_COLLECT) begin
      attack_d = (|attack_sum[SUM_W-1:DMG_W]) ? '1 : attack_sum[DMG_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_v_q      <= 1'b0;
      pend_type_q   <= TYPE_NONE;
      reserved_q    <= '0;
      unit_front_q  <= '0;
      attack_q      <= '0;
      attack_vld_q  <= 1'b0;
      front_idx_q   <= '0;
      front_pos_q   <= '0;
      front_valid_q <= 1'b0;
    end else begin
      pend_v_q      <= pend_v_d;
      pend_type_q   <= pend_type_d;
      reserved_q    <= reserved_d;
      unit_front_q  <= unit_front_d;
      attack_q      <= attack_d;
      attack_vld_q  <= (state_q == ST_COLLECT);
      front_idx_q   <= sel_idx;
      front_pos_q   <= sel_pos;
      front_valid_q <= sel_valid;
    end
  end

  assign unit_front   = unit_front_q;
  assign front_pos    = front_pos_q;
  assign front_valid  = front_valid_q;
  assign enemy_attack = attack_q;
  assign attack_valid = attack_vld_q;

endmodule

// File: tb/tb_enemy_wave_ctrl.sv
module tb_enemy_wave_ctrl;

  localparam int N  = 4;
  localparam int PW = 9;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            tick = 1'b0;
  logic            spawn_req = 1'b0;
  logic [1:0]      spawn_type = '0;
  logic [PW-1:0]   player_front = '0;
  logic [DW-1:0]   player_damage = '0;
  logic [N*PW-1:0] enemy_pos = '0;
  logic [N*DW-1:0] enemy_dmg = '0;
  logic [N-1:0]    enemy_dead = '1;

  logic [N-1:0]    can_spawn;
  logic [1:0]      spawn_type_out;
  logic            move_scen, damage_scen;
  logic [PW-1:0]   unit_front;
  logic [N*DW-1:0] damage_in;
  logic [PW-1:0]   front_pos;
  logic            front_valid;
  logic [DW-1:0]   enemy_attack;
  logic            attack_valid, spawn_drop, tick_overrun;

  always #5 clk = ~clk;

  enemy_wave_ctrl #(.N_SLOTS(N), .POS_W(PW), .DMG_W(DW)) dut (
    .clk(clk), .reset(reset), .tick(tick), .spawn_req(spawn_req), .spawn_type(spawn_type),
    .player_front(player_front), .player_damage(player_damage), .enemy_pos(enemy_pos),
    .enemy_dmg(enemy_dmg), .enemy_dead(enemy_dead), .can_spawn(can_spawn),
    .spawn_type_out(spawn_type_out), .move_scen(move_scen), .damage_scen(damage_scen),
    .unit_front(unit_front), .damage_in(damage_in), .front_pos(front_pos),
    .front_valid(front_valid), .enemy_attack(enemy_attack), .attack_valid(attack_valid),
    .spawn_drop(spawn_drop), .tick_overrun(tick_overrun)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Staged stimulus, applied just after the next rising edge
  logic            s_reset = 1'b1, s_tick = 1'b0, s_req = 1'b0;
  logic [1:0]      s_type = '0;
  logic [PW-1:0]   s_pfront = '0;
  logic [DW-1:0]   s_pdmg = '0;
  logic [N*PW-1:0] s_pos = '0;
  logic [N*DW-1:0] s_dmg = '0;
  logic [N-1:0]    s_dead = '1;

  // Behavioural model: phase counts steps since the accepted tick (0 = idle)
  int            m_phase;
  bit            m_pend_v;
  logic [1:0]    m_pend_type;
  bit [N-1:0]    m_res;
  logic [PW-1:0] m_ufront;
  logic [DW-1:0] m_att;
  bit            m_att_v;
  int            m_fidx;
  logic [PW-1:0] m_fpos;
  bit            m_fvalid;
  int            m_slot;

  logic [N-1:0]    e_can;
  logic [1:0]      e_type;
  logic [N*DW-1:0] e_din;
  bit              e_drop, e_ovr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_pend_v = 0; m_pend_type = '0; m_res = '0; m_ufront = '0;
    m_att = '0; m_att_v = 0; m_fidx = 0; m_fpos = '0; m_fvalid = 0;
  endtask

  task automatic model_expect();
    m_slot = -1;
    if (m_phase == 1 && m_pend_v)
      for (int i = 0; i < N; i++)
        if (m_slot < 0 && enemy_dead[i] && !m_res[i]) m_slot = i;
    e_can  = (m_slot >= 0) ? N'(1 << m_slot) : '0;
    e_type = (m_slot >= 0) ? m_pend_type : 2'b00;
    e_din  = '0;
    if (m_phase == 2 && m_fvalid) e_din[m_fidx*DW +: DW] = player_damage;
    e_drop = spawn_req && m_pend_v && (m_slot < 0);
    e_ovr  = tick && (m_phase != 0);
  endtask

  task automatic model_advance();
    int s, best;
    bit refill;
    m_att_v = (m_phase == 4);
    if (m_phase == 4) begin
      s = 0;
      for (int i = 0; i < N; i++) if (!enemy_dead[i]) s += int'(enemy_dmg[i*DW +: DW]);
      m_att = (s > 255) ? 8'd255 : DW'(s);
    end
    if (m_phase == 0) begin
      if (tick) begin m_phase = 1; m_ufront = player_front; end
    end else begin
      m_phase = (m_phase == 4) ? 0 : m_phase + 1;
    end
    for (int i = 0; i < N; i++) begin
      if (i == m_slot) m_res[i] = 1'b1;
      else if (!enemy_dead[i]) m_res[i] = 1'b0;
    end
    refill = spawn_req && (!m_pend_v || m_slot >= 0);
    if (m_slot >= 0) m_pend_v = 0;
    if (refill) begin m_pend_v = 1; m_pend_type = spawn_type; end
    // Front: first find the maximum live position, then the first slot holding it.
    best = -1;
    for (int i = 0; i < N; i++)
      if (!enemy_dead[i] && int'(enemy_pos[i*PW +: PW]) > best) best = int'(enemy_pos[i*PW +: PW]);
    m_fvalid = (best >= 0);
    m_fpos = m_fvalid ? PW'(best) : '0;
    m_fidx = 0;
    for (int i = N - 1; i >= 0; i--)
      if (!enemy_dead[i] && int'(enemy_pos[i*PW +: PW]) == best) m_fidx = i;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    reset = s_reset; tick = s_tick; spawn_req = s_req; spawn_type = s_type;
    player_front = s_pfront; player_damage = s_pdmg; enemy_pos = s_pos;
    enemy_dmg = s_dmg; enemy_dead = s_dead;
    s_tick = 1'b0; s_req = 1'b0;
    if (reset) model_reset();
    @(negedge clk);
    model_expect();
    chk("can_spawn",      64'(can_spawn),      64'(e_can));
    chk("spawn_type_out", 64'(spawn_type_out), 64'(e_type));
    chk("move_scen",      64'(move_scen),      64'(m_phase == 3));
    chk("damage_scen",    64'(damage_scen),    64'(m_phase == 2));
    chk("unit_front",     64'(unit_front),     64'(m_ufront));
    chk("damage_in",      64'(damage_in),      64'(e_din));
    chk("front_pos",      64'(front_pos),      64'(m_fpos));
    chk("front_valid",    64'(front_valid),    64'(m_fvalid));
    chk("enemy_attack",   64'(enemy_attack),   64'(m_att));
    chk("attack_valid",   64'(attack_valid),   64'(m_att_v));
    chk("spawn_drop",     64'(spawn_drop),     64'(e_drop));
    chk("tick_overrun",   64'(tick_overrun),   64'(e_ovr));
    if (!reset) model_advance();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  bit [N-1:0] alive;
  int         dep_cnt [N];
  int         pulses;

  initial begin
    model_reset();
    // Reset state
    step();
    chk("rst_can_spawn", 64'(can_spawn), 64'(0));
    chk("rst_front_valid", 64'(front_valid), 64'(0));
    chk("rst_attack", 64'(enemy_attack), 64'(0));
    step();
    s_reset = 1'b0;
    step();

    // Heavy spawn into slot 0; slot 0 stays reserved while it still reports dead
    s_dead = 4'b1111; s_req = 1; s_type = 2'b11; s_tick = 1; s_pfront = 9'd123;
    step();
    step();
    chk("t1_can_spawn", 64'(can_spawn), 64'(4'b0001));
    chk("t1_type", 64'(spawn_type_out), 64'(2'b11));
    chk("t1_unit_front", 64'(unit_front), 64'(9'd123));
    idle(4);
    s_req = 1; s_type = 2'b01; s_tick = 1;
    step();
    step();
    chk("t1_reserved_skip", 64'(can_spawn), 64'(4'b0010));
    s_dead = 4'b1100;
    idle(5);
    s_dead = 4'b1101; s_req = 1; s_type = 2'b10; s_tick = 1;
    step();
    step();
    chk("t1_reserved_clear", 64'(can_spawn), 64'(4'b0001));
    chk("t1_type2", 64'(spawn_type_out), 64'(2'b10));
    idle(4);

    // Tie at position 40 between slots 0 and 2: damage goes to slot 0 only
    s_dead = 4'b1010; s_pos = {9'd100, 9'd40, 9'd100, 9'd40}; s_pdmg = 8'd30; s_tick = 1;
    step();
    step();
    step();
    chk("t2_damage_in", 64'(damage_in), 64'(32'h0000_001E));
    chk("t2_front_pos", 64'(front_pos), 64'(9'd40));
    step();
    chk("t2_move_scen", 64'(move_scen), 64'(1));
    chk("t2_damage_off", 64'(damage_in), 64'(0));
    idle(2);

    // Saturating attack sum 15+0+100+200 -> 255, valid 5 cycles after tick
    s_dead = 4'b0000; s_dmg = {8'd200, 8'd100, 8'd0, 8'd15}; s_tick = 1;
    step();
    idle(4);
    step();
    chk("t3_attack_valid", 64'(attack_valid), 64'(1));
    chk("t3_attack_sat", 64'(enemy_attack), 64'(8'd255));
    step();
    chk("t3_attack_pulse", 64'(attack_valid), 64'(0));

    // All slots full: request stays pending across ticks until slot 3 frees
    s_req = 1; s_type = 2'b01; s_tick = 1;
    step();
    step();
    chk("t4_full0", 64'(can_spawn), 64'(0));
    idle(4);
    s_tick = 1;
    step();
    step();
    chk("t4_full1", 64'(can_spawn), 64'(0));
    idle(4);
    s_dead = 4'b1000; s_tick = 1;
    step();
    step();
    chk("t4_slot3", 64'(can_spawn), 64'(4'b1000));
    chk("t4_type", 64'(spawn_type_out), 64'(2'b01));
    idle(4);

    // Two requests back to back: second dropped, first type kept
    s_dead = 4'b0001; s_req = 1; s_type = 2'b10;
    step();
    chk("t5_no_drop", 64'(spawn_drop), 64'(0));
    s_req = 1; s_type = 2'b01;
    step();
    chk("t5_drop", 64'(spawn_drop), 64'(1));
    s_tick = 1;
    step();
    step();
    chk("t5_can", 64'(can_spawn), 64'(4'b0001));
    chk("t5_type_kept", 64'(spawn_type_out), 64'(2'b10));
    idle(4);

    // Early tick: overrun flagged, sequence runs once
    s_tick = 1;
    step();
    step();
    s_tick = 1;
    step();
    chk("t6_overrun", 64'(tick_overrun), 64'(1));
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (attack_valid) pulses++;
    end
    chk("t6_one_sequence", 64'(pulses), 64'(1));

    // Reset mid-sequence aborts without further strobes
    s_tick = 1;
    step();
    step();
    s_reset = 1;
    step();
    chk("t7_rst_damage", 64'(damage_scen), 64'(0));
    s_reset = 0;
    idle(7);

    // Randomized traffic with a simple enemy environment (deploy 2 cycles after can_spawn)
    alive = ~s_dead;
    for (int i = 0; i < N; i++) dep_cnt[i] = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (dep_cnt[i] > 0) begin
          dep_cnt[i]--;
          if (dep_cnt[i] == 0) alive[i] = 1'b1;
        end else if (alive[i] && ($urandom % 16 == 0)) begin
          alive[i] = 1'b0;
        end
        s_dead[i] = ~alive[i];
        s_pos[i*PW +: PW] = (cyc % 800 < 400) ? PW'($urandom_range(0, 7)) : PW'($urandom);
        s_dmg[i*DW +: DW] = DW'($urandom_range(0, (cyc % 1000 < 500) ? 60 : 255));
      end
      s_tick   = ($urandom % 4 == 0);
      s_req    = ($urandom % 5 == 0);
      s_type   = 2'($urandom);
      s_pfront = PW'($urandom);
      s_pdmg   = DW'($urandom);
      s_reset  = ($urandom % 700 == 0);
      step();
      for (int i = 0; i < N; i++) if (e_can[i]) dep_cnt[i] = 2;
    end
    s_reset = 0;
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
